scr1_dmem_router: RTL and testbench

Three-way router between the core data memory interface and its targets:
- port 0: TCM
- port 1: memory-mapped timer
- port 2: external bus bridge, the default target

It decodes each request address, forwards the request to exactly one target, and tracks the single outstanding transaction. Responses and read data are steered back to the core. Back-to-back accepts are supported, so the single-cycle TCM sustains one access per clock.

---
 rtl/scr1_dmem_router_pkg.sv | 41 ++++
 rtl/scr1_dmem_router.sv | 142 ++++++++++++++
 tb/tb_scr1_dmem_router.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_dmem_router_pkg.sv
// Shared memory-interface types, default data-memory address map and
// router-local encodings for scr1_dmem_router.
package scr1_dmem_router_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Default map: TCM window, then the 32-byte timer block; everything else is external.
  localparam logic [31:0] SCR1_DMEM_TCM_ADDR_MASK      = 32'hFFFF0000;
  localparam logic [31:0] SCR1_DMEM_TCM_ADDR_PATTERN   = 32'h00480000;
  localparam logic [31:0] SCR1_DMEM_TIMER_ADDR_MASK    = 32'hFFFFFFE0;
  localparam logic [31:0] SCR1_DMEM_TIMER_ADDR_PATTERN = 32'h00490000;

  localparam logic [1:0] SCR1_SEL_PORT0 = 2'd0;
  localparam logic [1:0] SCR1_SEL_PORT1 = 2'd1;
  localparam logic [1:0] SCR1_SEL_PORT2 = 2'd2;

  typedef enum logic {
    SCR1_FSM_IDLE = 1'b0,
    SCR1_FSM_WAIT = 1'b1
  } type_scr1_dmem_fsm_e;

endpackage

// File: rtl/scr1_dmem_router.sv
// Routes core data-memory requests to TCM, timer or external bridge and
// steers the single outstanding response back to the core.
//   state | meaning
//   IDLE  | nothing outstanding, core sees NOTRDY
//   WAIT  | one transaction outstanding on r_port_sel
module scr1_dmem_router
  import scr1_dmem_router_pkg::*;
#(
  parameter logic [31:0] SCR1_PORT0_ADDR_MASK    = SCR1_DMEM_TCM_ADDR_MASK,
  parameter logic [31:0] SCR1_PORT0_ADDR_PATTERN = SCR1_DMEM_TCM_ADDR_PATTERN,
  parameter logic [31:0] SCR1_PORT1_ADDR_MASK    = SCR1_DMEM_TIMER_ADDR_MASK,
  parameter logic [31:0] SCR1_PORT1_ADDR_PATTERN = SCR1_DMEM_TIMER_ADDR_PATTERN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          dmem_req_ack,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  input  logic                          port0_req_ack,
  output logic                          port0_req,
  output type_scr1_mem_cmd_e            port0_cmd,
  output type_scr1_mem_width_e          port0_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   port0_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]   port0_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   port0_rdata,
  input  type_scr1_mem_resp_e           port0_resp,
  input  logic                          port1_req_ack,
  output logic                          port1_req,
  output type_scr1_mem_cmd_e            port1_cmd,
  output type_scr1_mem_width_e          port1_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   port1_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]   port1_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   port1_rdata,
  input  type_scr1_mem_resp_e           port1_resp,
  input  logic                          port2_req_ack,
  output logic                          port2_req,
  output type_scr1_mem_cmd_e            port2_cmd,
  output type_scr1_mem_width_e          port2_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   port2_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]   port2_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   port2_rdata,
  input  type_scr1_mem_resp_e           port2_resp
);

  type_scr1_dmem_fsm_e         r_fsm;
  type_scr1_dmem_fsm_e         w_fsm_next;
  logic [1:0]                  r_port_sel;
  logic [1:0]                  w_port_sel_next;
  logic [1:0]                  w_new_sel;
  type_scr1_mem_resp_e         w_cur_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] w_cur_rdata;
  logic                        w_new_ack;
  logic                        w_can_issue;
  logic                        w_transfer;

  always_comb begin
    w_new_sel = SCR1_SEL_PORT2;
    if ((dmem_addr & SCR1_PORT0_ADDR_MASK) == SCR1_PORT0_ADDR_PATTERN) begin
      w_new_sel = SCR1_SEL_PORT0;
    end else if ((dmem_addr & SCR1_PORT1_ADDR_MASK) == SCR1_PORT1_ADDR_PATTERN) begin
      w_new_sel = SCR1_SEL_PORT1;
    end
  end

  always_comb begin
    w_cur_resp  = port2_resp;
    w_cur_rdata = port2_rdata;
    case (r_port_sel)
      SCR1_SEL_PORT0: begin
        w_cur_resp  = port0_resp;
        w_cur_rdata = port0_rdata;
      end
      SCR1_SEL_PORT1: begin
        w_cur_resp  = port1_resp;
        w_cur_rdata = port1_rdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_new_ack = port2_req_ack;
    case (w_new_sel)
      SCR1_SEL_PORT0: w_new_ack = port0_req_ack;
      SCR1_SEL_PORT1: w_new_ack = port1_req_ack;
      default: ;
    endcase
  end

  // A returning response frees the slot in the same cycle, so TCM streams without bubbles.
  assign w_can_issue  = (r_fsm == SCR1_FSM_IDLE) |
                        ((r_fsm == SCR1_FSM_WAIT) & (w_cur_resp != SCR1_MEM_RESP_NOTRDY));
  assign dmem_req_ack = w_can_issue & w_new_ack;
  assign w_transfer   = dmem_req & dmem_req_ack;

  assign port0_req = dmem_req & w_can_issue & (w_new_sel == SCR1_SEL_PORT0);
  assign port1_req = dmem_req & w_can_issue & (w_new_sel == SCR1_SEL_PORT1);
  assign port2_req = dmem_req & w_can_issue & (w_new_sel == SCR1_SEL_PORT2);

  assign port0_cmd   = dmem_cmd;
  assign port0_width = dmem_width;
  assign port0_addr  = dmem_addr;
  assign port0_wdata = dmem_wdata;
  assign port1_cmd   = dmem_cmd;
  assign port1_width = dmem_width;
  assign port1_addr  = dmem_addr;
  assign port1_wdata = dmem_wdata;
  assign port2_cmd   = dmem_cmd;
  assign port2_width = dmem_width;
  assign port2_addr  = dmem_addr;
  assign port2_wdata = dmem_wdata;

  assign dmem_resp  = (r_fsm == SCR1_FSM_WAIT) ? w_cur_resp  : SCR1_MEM_RESP_NOTRDY;
  assign dmem_rdata = (r_fsm == SCR1_FSM_WAIT) ? w_cur_rdata : '0;

  always_comb begin
    w_fsm_next      = r_fsm;
    w_port_sel_next = r_port_sel;
    if (w_transfer) begin
      w_fsm_next      = SCR1_FSM_WAIT;
      w_port_sel_next = w_new_sel;
    end else if ((r_fsm == SCR1_FSM_WAIT) && (w_cur_resp != SCR1_MEM_RESP_NOTRDY)) begin
      w_fsm_next = SCR1_FSM_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= SCR1_FSM_IDLE;
      r_port_sel <= SCR1_SEL_PORT0;
    end else begin
      r_fsm      <= w_fsm_next;
      r_port_sel <= w_port_sel_next;
    end
  end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Directed bench for scr1_dmem_router; expected responses are queued at
// request acceptance and popped when the core sees a ready response.
module tb_scr1_dmem_router;
  import scr1_dmem_router_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 dmem_req_ack, dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr, dmem_wdata, dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;

  logic                 port0_req_ack, port0_req, port1_req_ack, port1_req, port2_req_ack, port2_req;
  type_scr1_mem_cmd_e   port0_cmd, port1_cmd, port2_cmd;
  type_scr1_mem_width_e port0_width, port1_width, port2_width;
  logic [31:0]          port0_addr, port0_wdata, port0_rdata;
  logic [31:0]          port1_addr, port1_wdata, port1_rdata;
  logic [31:0]          port2_addr, port2_wdata, port2_rdata;
  type_scr1_mem_resp_e  port0_resp, port1_resp, port2_resp;

  scr1_dmem_router dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_req_ack(dmem_req_ack), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .port0_req_ack(port0_req_ack), .port0_req(port0_req), .port0_cmd(port0_cmd),
    .port0_width(port0_width), .port0_addr(port0_addr), .port0_wdata(port0_wdata),
    .port0_rdata(port0_rdata), .port0_resp(port0_resp),
    .port1_req_ack(port1_req_ack), .port1_req(port1_req), .port1_cmd(port1_cmd),
    .port1_width(port1_width), .port1_addr(port1_addr), .port1_wdata(port1_wdata),
    .port1_rdata(port1_rdata), .port1_resp(port1_resp),
    .port2_req_ack(port2_req_ack), .port2_req(port2_req), .port2_cmd(port2_cmd),
    .port2_width(port2_width), .port2_addr(port2_addr), .port2_wdata(port2_wdata),
    .port2_rdata(port2_rdata), .port2_resp(port2_resp)
  );

  typedef struct packed {
    type_scr1_mem_resp_e resp;
    logic [31:0]         rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] dec_addr [5] = '{32'h0048FFFF, 32'h00470000, 32'h0049001F, 32'h00490020, 32'h00480000};
  logic [2:0]  dec_reqs [5] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reqs(input string tag, input logic [2:0] exp_reqs, input logic exp_ack);
    chk({tag, "_reqs"}, 32'({port0_req, port1_req, port2_req}), 32'(exp_reqs));
    chk({tag, "_ack"}, 32'(dmem_req_ack), 32'(exp_ack));
  endtask

  task automatic push(input type_scr1_mem_resp_e r, input logic [31:0] d);
    exp_t e;
    e.resp  = r;
    e.rdata = d;
    sb_q.push_back(e);
  endtask

  // Called after inputs settle each cycle; pops one expectation per ready response.
  task automatic mon();
    exp_t e;
    if (dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      end else begin
        e = sb_q.pop_front();
        chk("sb_resp", 32'(dmem_resp), 32'(e.resp));
        chk("sb_rdata", dmem_rdata, e.rdata);
      end
    end
  endtask

  task automatic drive(input logic req, input type_scr1_mem_cmd_e cmd, input logic [31:0] addr,
                       input logic [31:0] wd);
    dmem_req   = req;
    dmem_cmd   = cmd;
    dmem_addr  = addr;
    dmem_wdata = wd;
  endtask

  task automatic tgt(input type_scr1_mem_resp_e r0, input logic [31:0] d0,
                     input type_scr1_mem_resp_e r1, input logic [31:0] d1,
                     input type_scr1_mem_resp_e r2, input logic [31:0] d2);
    port0_resp = r0; port0_rdata = d0;
    port1_resp = r1; port1_rdata = d1;
    port2_resp = r2; port2_rdata = d2;
  endtask

  task automatic tgt_idle();
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0);
  endtask

  task automatic settle();
    #1;
    mon();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_resp"}, 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk({tag, "_rdata"}, dmem_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dmem_width = SCR1_MEM_WIDTH_WORD;
    drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    port0_req_ack = 1'b0; port1_req_ack = 1'b0; port2_req_ack = 1'b0;
    tgt_idle();
    #2;
    chk_idle("rst");
    chk_reqs("rst", 3'b000, 1'b0);
    chk("rst_sel", 32'(dut.r_port_sel), 32'(SCR1_SEL_PORT0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    port0_req_ack = 1'b1; port1_req_ack = 1'b1; port2_req_ack = 1'b1;

    // 1: single TCM read; a stray port1 response must be ignored
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h00480010, 32'h0); tgt_idle(); settle();
    chk_reqs("t1_issue", 3'b100, 1'b1);
    push(SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF);
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    tgt(SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, SCR1_MEM_RESP_RDY_ER, 32'h12345678,
        SCR1_MEM_RESP_NOTRDY, 32'h0);
    settle();
    chk("t1_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    @(negedge clk); tgt_idle(); settle();
    chk_idle("t1_back_idle");

    // 2: back-to-back TCM reads
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h00480000, 32'h0); settle();
    chk_reqs("t2_first", 3'b100, 1'b1);
    push(SCR1_MEM_RESP_RDY_OK, 32'h11111111);
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h00480004, 32'h0);
    tgt(SCR1_MEM_RESP_RDY_OK, 32'h11111111, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0);
    settle();
    chk_reqs("t2_second", 3'b100, 1'b1);
    chk("t2_first_data", dmem_rdata, 32'h11111111);
    push(SCR1_MEM_RESP_RDY_OK, 32'h22222222);
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    tgt(SCR1_MEM_RESP_RDY_OK, 32'h22222222, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0);
    settle();
    chk("t2_second_data", dmem_rdata, 32'h22222222);
    @(negedge clk); tgt_idle(); settle();
    chk_idle("t2_back_idle");

    // 3: timer write, then external write stalled behind it, then 3 NOTRDY cycles
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_WR, 32'h00490008, 32'hA5A5A5A5); settle();
    chk_reqs("t3_timer", 3'b010, 1'b1);
    chk("t3_bcast_wdata", port1_wdata, 32'hA5A5A5A5);
    push(SCR1_MEM_RESP_RDY_OK, 32'h0);
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_WR, 32'h20000000, 32'h5A5A5A5A); settle();
    chk_reqs("t3_blocked", 3'b000, 1'b0);
    @(negedge clk);
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0);
    settle();
    chk_reqs("t3_fwd", 3'b001, 1'b1);
    chk("t3_bcast_addr", port2_addr, 32'h20000000);
    chk("t3_bcast_cmd", 32'(port2_cmd), 32'(SCR1_MEM_CMD_WR));
    push(SCR1_MEM_RESP_RDY_OK, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0); tgt_idle(); settle();
      chk($sformatf("t3_wait%0d", i), 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    end
    @(negedge clk);
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h0);
    settle();
    chk("t3_done", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    @(negedge clk); tgt_idle(); settle();
    chk_idle("t3_back_idle");

    // 4: TCM request held off behind outstanding external read
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h20000004, 32'h0); settle();
    chk_reqs("t4_ext", 3'b001, 1'b1);
    push(SCR1_MEM_RESP_RDY_OK, 32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h00480000, 32'h0); settle();
      chk_reqs($sformatf("t4_hold%0d", i), 3'b000, 1'b0);
    end
    @(negedge clk);
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hCAFEF00D);
    settle();
    chk_reqs("t4_release", 3'b100, 1'b1);
    push(SCR1_MEM_RESP_RDY_OK, 32'h55AA55AA);
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    tgt(SCR1_MEM_RESP_RDY_OK, 32'h55AA55AA, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h99999999);
    settle();
    @(negedge clk); tgt_idle(); settle();
    chk_idle("t4_back_idle");

    // 5: error response ends the transaction; next request routes normally
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h30000000, 32'h0); settle();
    chk_reqs("t5_ext", 3'b001, 1'b1);
    push(SCR1_MEM_RESP_RDY_ER, 32'h0);
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_ER, 32'h0);
    settle();
    chk("t5_err", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
    @(negedge clk); tgt_idle(); settle();
    chk_idle("t5_back_idle");
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h00490010, 32'h0); settle();
    chk_reqs("t5_next", 3'b010, 1'b1);
    push(SCR1_MEM_RESP_RDY_OK, 32'h13579BDF);
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h13579BDF, SCR1_MEM_RESP_NOTRDY, 32'h0);
    settle();
    @(negedge clk); tgt_idle(); settle();

    // Decode boundaries with all targets refusing, plus a held unacknowledged request
    port0_req_ack = 1'b0; port1_req_ack = 1'b0; port2_req_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, dec_addr[i], 32'h0); settle();
      chk_reqs($sformatf("dec%0d", i), dec_reqs[i], 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h00490004, 32'h0);
      tgt(SCR1_MEM_RESP_RDY_OK, 32'h1, SCR1_MEM_RESP_RDY_OK, 32'h2, SCR1_MEM_RESP_RDY_OK, 32'h3);
      settle();
      chk_reqs($sformatf("noack%0d", i), 3'b010, 1'b0);
      chk_idle($sformatf("noack%0d", i));
    end
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0); tgt_idle(); settle();
    port0_req_ack = 1'b1; port1_req_ack = 1'b1; port2_req_ack = 1'b1;

    // 6: reset while external access outstanding drops the response
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h20000000, 32'h0); settle();
    chk_reqs("t6_ext", 3'b001, 1'b1);
    push(SCR1_MEM_RESP_RDY_OK, 32'h77777777);
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0); settle();
    chk("t6_sel_ext", 32'(dut.r_port_sel), 32'(SCR1_SEL_PORT2));
    @(negedge clk);
    rst_n = 1'b0;
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h77777777);
    #1;
    chk_idle("t6_rst");
    chk_reqs("t6_rst", 3'b000, 1'b1);
    chk("t6_rst_sel", 32'(dut.r_port_sel), 32'(SCR1_SEL_PORT0));
    sb_q.delete();
    @(negedge clk); rst_n = 1'b1; tgt_idle();
    @(negedge clk); drive(1'b1, SCR1_MEM_CMD_RD, 32'h00490004, 32'h0); settle();
    chk_reqs("t6_timer", 3'b010, 1'b1);
    push(SCR1_MEM_RESP_RDY_OK, 32'h600DF00D);
    @(negedge clk); drive(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
    tgt(SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h600DF00D, SCR1_MEM_RESP_RDY_OK, 32'h77777777);
    settle();
    chk("t6_timer_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    @(negedge clk); tgt_idle(); settle();
    chk_idle("t6_back_idle");

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
